// File: rtl/fsm_stream_proc_pkg.sv
// fsm_stream_pkg: shared definitions for the streaming word-processing FSM.
//   - state_t   : one-hot 9-bit state encoding (S_IDLE..S_ERROR)
//   - DEF_*     : default READ/CLR keys and error code
//   - emit_word : word emitted for a given processing state and input word.
//                 It works at MAX_DW bits; callers truncate to their width.
//                 The low DW bits are exact for +1, <<1 and ~.
package fsm_stream_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [8:0] {
    S_IDLE  = 9'b0_0000_0001,
    S_START = 9'b0_0000_0010,
    S_READ  = 9'b0_0000_0100,
    S_PROC1 = 9'b0_0000_1000,
    S_PROC2 = 9'b0_0001_0000,
    S_PROC3 = 9'b0_0010_0000,
    S_WAIT  = 9'b0_0100_0000,
    S_DONE  = 9'b0_1000_0000,
    S_ERROR = 9'b1_0000_0000
  } state_t;

  localparam logic [2:0] DEF_READ_KEY = 3'b101;
  localparam logic [2:0] DEF_CLR_KEY  = 3'b111;
  localparam logic [7:0] DEF_ERR_CODE = 8'hEE;

  function automatic logic [MAX_DW-1:0] emit_word(input state_t st,
                                                  input logic [MAX_DW-1:0] d);
    case (st)
      S_PROC1: return d + MAX_DW'(1);
      S_PROC2: return d << 1;
      S_PROC3: return ~d;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/fsm_stream_proc_out_slot.sv
// fsm_out_slot: one-entry registered output slot with valid/ready and a done
// side-bit. A load always wins; otherwise a handshake empties the slot.
// The producer must only load when !out_valid || out_ready.
//   clk, rst       : clock, asynchronous active-high reset
//   load           : capture load_data/load_done and raise out_valid
//   load_data      : word to present
//   load_done      : side-bit presented with the word
//   out_ready      : consumer accepts data_out
//   out_valid      : slot holds a word
//   data_out, done : registered word and its side-bit
module fsm_out_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] data_out,
  output logic          done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_out  <= load_data;
      done      <= load_done;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      done      <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_stream_proc.sv
// fsm_stream_proc: parametrised word-processing FSM with valid/ready streams.
// Flow IDLE->START->READ->PROC1..3->DONE with WAIT (timeout/retry) and ERROR
// detours. Every emitted word is XOR-folded into a checksum that is emitted
// with done=1 from DONE. DW must be in 8..64.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : begin a transaction (IDLE only)
//   in_valid/in_ready  : input handshake for data_in
//   data_in            : input word
//   out_valid/out_ready: output handshake for data_out
//   data_out           : registered output word
//   done               : marks the checksum beat
//   err                : FSM is in ERROR
//   busy               : FSM is not in IDLE
//   retry_cnt          : WAIT->READ retries used in this transaction
module fsm_stream_proc
  import fsm_stream_pkg::*;
#(
  parameter int         DW        = 8,
  parameter logic [2:0] READ_KEY  = DEF_READ_KEY,
  parameter logic [2:0] CLR_KEY   = DEF_CLR_KEY,
  parameter logic [7:0] ERR_CODE  = DEF_ERR_CODE,
  parameter int         WAIT_MAX  = 15,
  parameter int         MAX_RETRY = 3,
  localparam int        RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic [RW-1:0] retry_cnt
);

  localparam int            TW       = $clog2(WAIT_MAX + 1);
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_CODE);

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] checksum;
  logic          err_sent;
  logic          slot_free, take, timeout;
  logic          emit, emit_done;
  logic [DW-1:0] emit_data, proc_word;

  assign slot_free = !out_valid || out_ready;
  assign take      = in_valid && in_ready;
  assign timeout   = (tcnt == TW'(WAIT_MAX - 1));
  assign proc_word = DW'(emit_word(state, MAX_DW'(data_in)));
  assign busy      = (state != S_IDLE);
  assign err       = (state == S_ERROR);

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_START, S_WAIT, S_ERROR:          in_ready = 1'b1;
      S_READ, S_PROC1, S_PROC2, S_PROC3: in_ready = slot_free;
      default:                           in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_done = 1'b0;
    emit_data = proc_word;
    case (state)
      S_IDLE:  if (start) state_nxt = S_START;
      S_START: if (take) state_nxt = data_in[0] ? S_READ : S_ERROR;
      S_READ: if (take) begin
        emit      = 1'b1;
        state_nxt = (data_in[3:1] == READ_KEY) ? S_PROC1 : S_WAIT;
      end
      S_PROC1: if (take) begin
        emit      = 1'b1;
        state_nxt = S_PROC2;
      end
      S_PROC2: if (take) begin
        emit      = 1'b1;
        state_nxt = data_in[DW-1] ? S_PROC3 : S_WAIT;
      end
      S_PROC3: if (take) begin
        emit      = 1'b1;
        state_nxt = S_DONE;
      end
      // A qualifying take beats a timeout landing in the same cycle.
      S_WAIT: begin
        if (take && data_in[4])
          state_nxt = (retry_cnt < RW'(MAX_RETRY)) ? S_READ : S_ERROR;
        else if (timeout)
          state_nxt = S_ERROR;
      end
      S_DONE: if (slot_free) begin
        emit      = 1'b1;
        emit_done = 1'b1;
        emit_data = checksum;
        state_nxt = S_IDLE;
      end
      // Input is swallowed until the error code has been placed in the slot.
      S_ERROR: begin
        if (!err_sent) begin
          if (slot_free) begin
            emit      = 1'b1;
            emit_data = ERR_WORD;
          end
        end else if (take && data_in[2:0] == CLR_KEY) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      retry_cnt <= '0;
      checksum  <= '0;
      err_sent  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        retry_cnt <= '0;
        checksum  <= '0;
      end else begin
        if (emit) checksum <= checksum ^ emit_data;
        if (state == S_WAIT && state_nxt == S_READ) retry_cnt <= retry_cnt + 1'b1;
      end
      if (state == S_WAIT && state_nxt == S_WAIT) tcnt <= tcnt + 1'b1;
      else                                        tcnt <= '0;
      err_sent <= (state == S_ERROR) && (err_sent || emit);
    end
  end

  // Output register stage: emit -> data_out/out_valid one cycle later.
  fsm_out_slot #(.DW(DW)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (emit),
    .load_data (emit_data),
    .load_done (emit_done),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .done      (done)
  );

endmodule

// File: tb/tb_fsm_stream_proc.sv
module tb_fsm_stream_proc;

  localparam int DW        = 8;
  localparam int WAIT_MAX  = 4;
  localparam int MAX_RETRY = 2;
  localparam int RW        = $clog2(MAX_RETRY + 1);

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready;
  logic          done, err, busy;
  logic [DW-1:0] data_in, data_out;
  logic [RW-1:0] retry_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          dn;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int    total = 0;
  int    bad   = 0;
  logic  done_seen = 1'b0;

  always #5 clk = ~clk;

  fsm_stream_proc #(
    .DW(DW), .WAIT_MAX(WAIT_MAX), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .done(done), .err(err), .busy(busy), .retry_cnt(retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic dn);
    beat_t b;
    b.d  = d;
    b.dn = dn;
    sb.push_back(b);
  endtask

  task automatic send(input logic [DW-1:0] w);
    int n;
    n        = 0;
    in_valid = 1'b1;
    data_in  = w;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL send_stall got=%0d exp=<50", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  // Scoreboard: a beat is consumed at the edge following a negedge that
  // shows out_valid && out_ready outside reset.
  always @(negedge clk) begin
    if (done) done_seen = 1'b1;
    if (!rst && out_valid && out_ready) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_beat got=%0h exp=none", data_out);
      end
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        total++;
        assert (data_out === exp_b.d && done === exp_b.dn) else begin
          bad++;
          $error("FAIL beat got=%0h/%0b exp=%0h/%0b", data_out, done, exp_b.d, exp_b.dn);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_retry", retry_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("idle_in_ready", in_ready, 0);

    // Happy path
    start = 1'b1; cyc(); start = 1'b0;
    chk("hp_busy", busy, 1);
    send(8'h01);
    expect_beat(8'h0A, 1'b0); send(8'h0A);
    chk("hp_lat_valid", out_valid, 1);
    chk("hp_lat_data", data_out, 8'h0A);
    expect_beat(8'h11, 1'b0); send(8'h10);
    expect_beat(8'h00, 1'b0); send(8'h80);
    expect_beat(8'hCC, 1'b0); send(8'h33);
    expect_beat(8'hD7, 1'b1);
    wait_idle("hp_idle");
    chk("hp_done_beat", done & out_valid, 1);
    cyc();
    chk("hp_done_clear", done, 0);
    cyc();
    chk("hp_drain", sb.size(), 0);

    // Error path
    start = 1'b1; cyc(); start = 1'b0;
    expect_beat(8'hEE, 1'b0); send(8'h00);
    chk("er_err", err, 1);
    cyc();
    send(8'h05);
    chk("er_hold", err, 1);
    send(8'h07);
    chk("er_clear", err, 0);
    chk("er_idle", busy, 0);
    cyc();
    chk("er_drain", sb.size(), 0);

    // Backpressure
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h01);
    expect_beat(8'h0A, 1'b0); send(8'h0A);
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'h10;
    repeat (3) cyc();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold_data", data_out, 8'h0A);
    chk("bp_hold_valid", out_valid, 1);
    expect_beat(8'h11, 1'b0);
    out_ready = 1'b1;
    send(8'h10);
    expect_beat(8'h00, 1'b0); send(8'h80);
    expect_beat(8'hCC, 1'b0); send(8'h33);
    expect_beat(8'hD7, 1'b1);
    wait_idle("bp_idle");
    repeat (2) cyc();
    chk("bp_drain", sb.size(), 0);

    // WAIT timeout
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h01);
    expect_beat(8'h00, 1'b0); send(8'h00);
    repeat (3) cyc();
    chk("to_not_yet", err, 0);
    expect_beat(8'hEE, 1'b0);
    cyc();
    chk("to_err", err, 1);
    cyc();
    send(8'h07);
    chk("to_clear", busy, 0);
    cyc();
    chk("to_drain", sb.size(), 0);

    // Retry limit
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h01);
    expect_beat(8'h00, 1'b0); send(8'h00);
    send(8'h10);
    chk("rt_retry1", retry_cnt, 1);
    expect_beat(8'h00, 1'b0); send(8'h00);
    send(8'h10);
    chk("rt_retry2", retry_cnt, 2);
    expect_beat(8'h00, 1'b0); send(8'h00);
    expect_beat(8'hEE, 1'b0); send(8'h10);
    chk("rt_err", err, 1);
    chk("rt_retry_hold", retry_cnt, 2);
    cyc();
    send(8'h07);
    cyc();
    chk("rt_drain", sb.size(), 0);

    // Async reset mid-PROC2
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h01);
    expect_beat(8'h0A, 1'b0); send(8'h0A);
    expect_beat(8'h11, 1'b0); send(8'h10);
    chk("ar_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", data_out, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_busy", busy, 0);
    chk("ar_retry", retry_cnt, 0);
    chk("ar_pending", sb.size(), 1);
    sb.delete();
    done_seen = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("ar_no_done", done_seen, 0);
    chk("ar_idle", busy, 0);

    chk("final_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
